// File: rtl/adex_spike_monitor.sv
// Spike event monitor: timestamps rising edges of spike_in, queues {lost, ts}
// events in a small FIFO and streams each one as a 3-byte packet (HDR, TSH, TSL).
module adex_spike_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       spike_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] drop_count,
  output logic [4:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = TS_WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_TSH  = 2'd2;
  localparam logic [1:0] ST_TSL  = 2'd3;

  logic [TS_WIDTH-1:0] ts_cnt;
  logic                spike_q;
  logic                lost_q;
  logic [7:0]          drop_q;
  logic [4:0]          level_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [ENT_W-1:0]    pkt_q;
  logic [1:0]          state;

  logic handshake;
  logic fifo_nonempty;
  logic fifo_full;
  logic detect;
  logic pop;
  logic push;
  logic drop;

  assign tx_valid      = (state != ST_IDLE);
  assign handshake     = tx_valid & tx_ready;
  assign fifo_nonempty = (level_q != 5'd0);
  assign fifo_full     = (level_q == 5'(FIFO_DEPTH));
  assign detect        = enable & spike_in & ~spike_q;

  // A pop frees a slot on the same edge, so a detection while full still fits.
  assign pop  = fifo_nonempty & ((state == ST_IDLE) | ((state == ST_TSL) & handshake));
  assign push = detect & (~fifo_full | pop);
  assign drop = detect & fifo_full & ~pop;

  assign drop_count = drop_q;
  assign fifo_level = level_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt  <= '0;
      spike_q <= 1'b0;
      lost_q  <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      spike_q <= spike_in;
      if (enable)
        ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (push)
        lost_q <= 1'b0;
      else if (drop)
        lost_q <= 1'b1;
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and level alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {lost_q, ts_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= 5'd0;
      pkt_q   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        pkt_q  <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (fifo_nonempty) state <= ST_HDR;
        ST_HDR:  if (handshake) state <= ST_TSH;
        ST_TSH:  if (handshake) state <= ST_TSL;
        ST_TSL:  if (handshake) state <= fifo_nonempty ? ST_HDR : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: tx_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_HDR:  tx_data = {4'hA, 3'b000, pkt_q[TS_WIDTH]};
      ST_TSH:  tx_data = pkt_q[15:8];
      ST_TSL:  tx_data = pkt_q[7:0];
      default: tx_data = 8'h00;
    endcase
  end

endmodule
